// File: rtl/status_pkg.sv
// Shared definitions for the host status reporter: FSM states, frame layout
// and the default frame header.
package status_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam int unsigned FRAME_LEN = 5;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] IDX_HDR  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_DISC = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_EVT  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(4);

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/status_reporter_if.sv
// Byte-wide valid/ready link carrying status frames back to the host.
interface status_reporter_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/status_reporter_full_event_counter.sv
// Counts rising edges of the FIFO-full flag, saturating at 255, with a clear
// that still credits an edge seen in the clearing cycle.
module full_event_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fifo_full,
    input  logic       clear,
    output logic [7:0] count
);

    logic fifo_full_q;
    logic rise;

    assign rise = fifo_full & ~fifo_full_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_full_q <= 1'b0;
            count       <= '0;
        end else begin
            fifo_full_q <= fifo_full;
            if (clear) begin
                count <= {7'd0, rise};
            end else if (rise && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/status_reporter.sv
// Streams a 5-byte status frame (header, flags+seq, threshold, full-event
// count, XOR checksum) to the host on request or on a periodic timer.
module status_reporter
    import status_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned POLL_PERIOD = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              report_req,
    input  logic              pcstatus,
    input  logic              fifo_full,
    input  logic [7:0]        discriminator,
    status_reporter_if.master tx,
    output logic              busy
);

    localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             pending;
    logic [1:0]       seq;
    logic [TW-1:0]    timer;
    logic             poll_fire;
    logic             trigger;
    logic             start;

    logic             snap_pcstatus;
    logic             snap_fifo_full;
    logic [7:0]       snap_discriminator;
    logic [7:0]       snap_full_events;
    logic [7:0]       full_events;

    logic [7:0]       status_byte;
    logic [7:0]       next_byte;

    assign poll_fire = (POLL_PERIOD != 0) && (timer == TW'(POLL_PERIOD - 1));
    assign trigger   = report_req | poll_fire;
    assign start     = (state == IDLE) && (trigger || pending);
    assign next_idx  = idx + IDX_W'(1);

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;

    full_event_counter u_full_event_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .fifo_full (fifo_full),
        .clear     (start),
        .count     (full_events)
    );

    always_comb begin
        status_byte = {snap_pcstatus, snap_fifo_full, 4'b0000, seq};
        next_byte   = HEADER;
        case (next_idx)
            IDX_STAT: next_byte = status_byte;
            IDX_DISC: next_byte = snap_discriminator;
            IDX_EVT:  next_byte = snap_full_events;
            IDX_CHK:  next_byte = frame_checksum(HEADER, status_byte,
                                                 snap_discriminator, snap_full_events);
            default:  next_byte = HEADER;
        endcase
    end

    // Period timer free-runs, independent of frame activity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (POLL_PERIOD != 0) begin
            timer <= poll_fire ? '0 : timer + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            idx                <= IDX_HDR;
            data_q             <= '0;
            valid_q            <= 1'b0;
            busy               <= 1'b0;
            pending            <= 1'b0;
            seq                <= '0;
            snap_pcstatus      <= 1'b0;
            snap_fifo_full     <= 1'b0;
            snap_discriminator <= '0;
            snap_full_events   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state              <= SEND;
                        idx                <= IDX_HDR;
                        data_q             <= HEADER;
                        valid_q            <= 1'b1;
                        busy               <= 1'b1;
                        pending            <= 1'b0;
                        snap_pcstatus      <= pcstatus;
                        snap_fifo_full     <= fifo_full;
                        snap_discriminator <= discriminator;
                        snap_full_events   <= full_events;
                    end
                end
                SEND: begin
                    // Includes a trigger coinciding with checksum acceptance.
                    if (trigger) begin
                        pending <= 1'b1;
                    end
                    if (tx.tx_ready) begin
                        if (idx == IDX_CHK) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            busy    <= 1'b0;
                            seq     <= seq + 2'd1;
                        end else begin
                            idx    <= next_idx;
                            data_q <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_reporter.sv
// Directed bench for status_reporter: frames are queued as hand-computed bytes
// and a negedge monitor checks each accepted byte and handshake stability.
module tb_status_reporter;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       report_req;
    logic       pcstatus;
    logic       fifo_full;
    logic [7:0] disc;
    logic       ready0;
    logic       busy0;

    logic       rst1_n;
    logic       req1;
    logic       pc1;
    logic       ff1;
    logic [7:0] disc1;
    logic       busy1;

    status_reporter_if if0 ();
    status_reporter_if if1 ();

    assign if0.tx_ready = ready0;
    assign if1.tx_ready = 1'b1;

    status_reporter #(.HEADER(8'hA5), .POLL_PERIOD(0)) dut0 (
        .clock         (clock),
        .reset_n       (reset_n),
        .report_req    (report_req),
        .pcstatus      (pcstatus),
        .fifo_full     (fifo_full),
        .discriminator (disc),
        .tx            (if0),
        .busy          (busy0)
    );

    status_reporter #(.HEADER(8'hA5), .POLL_PERIOD(20)) dut1 (
        .clock         (clock),
        .reset_n       (rst1_n),
        .report_req    (req1),
        .pcstatus      (pc1),
        .fifo_full     (ff1),
        .discriminator (disc1),
        .tx            (if1),
        .busy          (busy1)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for dut0
    always @(negedge clock) begin
        if (reset_n) begin
            if (hold_v) begin
                check("hold_valid", {31'd0, if0.tx_valid}, 32'd1);
                check("hold_data", {24'd0, if0.tx_data}, {24'd0, hold_d});
            end
            if (if0.tx_valid && if0.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", if0.tx_data);
                end else begin
                    check("frame_byte", {24'd0, if0.tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            hold_v = if0.tx_valid && !if0.tx_ready;
            hold_d = if0.tx_data;
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    task automatic req_pulse();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy0 || if0.tx_valid) && n < bound) begin
            tick();
            n++;
        end
        if (busy0 || if0.tx_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy expected idle within %0d cycles", bound);
        end
    endtask

    // Waits for a 0->1 transition of dut1 tx_valid; returns negedges counted.
    task automatic wait_b0_dut1(output int gap, output bit found);
        logic pv;
        pv    = if1.tx_valid;
        gap   = 0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            gap++;
            if (if1.tx_valid && !pv) begin
                found = 1'b1;
                break;
            end
            pv = if1.tx_valid;
        end
    endtask

    initial begin
        int   gap;
        bit   found;
        logic extra;

        reset_n    = 1'b0;
        rst1_n     = 1'b0;
        report_req = 1'b0;
        pcstatus   = 1'b0;
        fifo_full  = 1'b0;
        disc       = 8'h00;
        ready0     = 1'b1;
        req1       = 1'b0;
        pc1        = 1'b0;
        ff1        = 1'b0;
        disc1      = 8'h11;
        repeat (3) tick();

        @(negedge clock);
        check("rst_valid", {31'd0, if0.tx_valid}, 32'd0);
        check("rst_data", {24'd0, if0.tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        tick();
        reset_n  = 1'b1;
        pcstatus = 1'b1;
        disc     = 8'h48;
        tick();

        // Basic frame and first-byte latency
        push5(8'hA5, 8'h80, 8'h48, 8'h00, 8'h6D);
        report_req = 1'b1;
        @(negedge clock);
        check("req_cycle_valid", {31'd0, if0.tx_valid}, 32'd0);
        tick();
        report_req = 1'b0;
        @(negedge clock);
        check("b0_latency_valid", {31'd0, if0.tx_valid}, 32'd1);
        check("b0_latency_data", {24'd0, if0.tx_data}, 32'hA5);
        check("b0_busy", {31'd0, busy0}, 32'd1);
        tick();
        wait_idle(20);

        // Three full events, then a cleared count
        repeat (3) begin
            fifo_full = 1'b1;
            tick();
            fifo_full = 1'b0;
            tick();
        end
        push5(8'hA5, 8'h81, 8'h48, 8'h03, 8'h6F);
        req_pulse();
        wait_idle(20);
        push5(8'hA5, 8'h82, 8'h48, 8'h00, 8'h6F);
        req_pulse();
        wait_idle(20);

        // Saturation
        repeat (300) begin
            fifo_full = 1'b1;
            tick();
            fifo_full = 1'b0;
            tick();
        end
        push5(8'hA5, 8'h83, 8'h48, 8'hFF, 8'h91);
        req_pulse();
        wait_idle(20);

        // Random back-pressure, threshold changed mid-frame
        pcstatus  = 1'b0;
        disc      = 8'h3C;
        fifo_full = 1'b1;
        repeat (3) tick();
        push5(8'hA5, 8'h40, 8'h3C, 8'h01, 8'hD8);
        req_pulse();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            ready0 = 1'($urandom_range(0, 1));
            if (i == 2) disc = 8'hFF;
            tick();
            if (!busy0 && !if0.tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("backpressure_done", {31'd0, found}, 32'd1);
        ready0    = 1'b1;
        fifo_full = 1'b0;
        pcstatus  = 1'b1;
        disc      = 8'h48;
        wait_idle(20);

        // Two requests mid-frame collapse into one pending frame
        push5(8'hA5, 8'h81, 8'h48, 8'h00, 8'h6C);
        push5(8'hA5, 8'h82, 8'h48, 8'h00, 8'h6F);
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        tick();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        tick();
        report_req = 1'b1;
        tick();
        report_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (if0.tx_valid && if0.tx_ready && if0.tx_data == 8'h6C) begin
                found = 1'b1;
                break;
            end
        end
        check("b4_seen", {31'd0, found}, 32'd1);
        @(negedge clock);
        check("gap_valid", {31'd0, if0.tx_valid}, 32'd0);
        @(negedge clock);
        check("pending_b0_valid", {31'd0, if0.tx_valid}, 32'd1);
        check("pending_b0_data", {24'd0, if0.tx_data}, 32'hA5);
        wait_idle(20);
        extra = 1'b0;
        repeat (10) begin
            @(negedge clock);
            extra = extra | if0.tx_valid;
        end
        check("no_extra_frame", {31'd0, extra}, 32'd0);

        // Rising edge in the snapshot cycle survives the clear
        tick();
        report_req = 1'b1;
        fifo_full  = 1'b1;
        push5(8'hA5, 8'hC3, 8'h48, 8'h00, 8'h2E);
        tick();
        report_req = 1'b0;
        wait_idle(20);
        fifo_full = 1'b0;
        tick();
        push5(8'hA5, 8'h80, 8'h48, 8'h01, 8'h6C);
        req_pulse();
        wait_idle(20);
        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        // Periodic reports on dut1, then reset mid-frame
        rst1_n = 1'b1;
        wait_b0_dut1(gap, found);
        check("poll_first", {31'd0, found}, 32'd1);
        repeat (2) begin
            wait_b0_dut1(gap, found);
            check("poll_period", gap, 32'd20);
            check("poll_hdr", {24'd0, if1.tx_data}, 32'hA5);
        end
        @(negedge clock);
        @(negedge clock);
        check("poll_b2", {24'd0, if1.tx_data}, 32'h11);
        #2;
        rst1_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, if1.tx_valid}, 32'd0);
        check("abort_data", {24'd0, if1.tx_data}, 32'd0);
        check("abort_busy", {31'd0, busy1}, 32'd0);
        tick();
        rst1_n = 1'b1;
        wait_b0_dut1(gap, found);
        check("post_reset_b0", {31'd0, found}, 32'd1);
        @(negedge clock);
        check("post_reset_seq", {24'd0, if1.tx_data}, 32'h00);
        repeat (3) @(negedge clock);
        check("post_reset_chk", {24'd0, if1.tx_data}, 32'hB4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_reporter.md
# status_reporter

Returns acquisition status to the host, in the opposite direction from the host command decoder. That decoder turns host instruction bytes into the run flag (`pcstatus`) and the discriminator threshold. This block packs the current run flag, FIFO back-pressure, the threshold and a count of FIFO-full events into a fixed 5-byte frame. It streams the frame over the same 8-bit host link on a valid/ready handshake, either when the host requests it or on a periodic timer.

## Interface
- `HEADER`, 8'hA5, first byte of every frame
- `POLL_PERIOD`, 0, number of cycles between automatic reports; 0 disables automatic reports
- `clock`  in  1  single system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `report_req`  in  1  one-cycle request for a status frame
- `pcstatus`  in  1  run flag from the command decoder
- `fifo_full`  in  1  acquisition FIFO full flag
- `discriminator`  in  8  current threshold from the command decoder
- `tx_data`  out  8  frame byte
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  host link accepts the byte when `tx_valid & tx_ready`
- `busy`  out  1  a frame is in progress

## Operation
- Frame bytes, in order:
  - B0 = `HEADER`
  - B1 = {snap_pcstatus, snap_fifo_full, 4'b0000, seq[1:0]}
  - B2 = snap_discriminator
  - B3 = snap_full_events
  - B4 = B0^B1^B2^B3
- Snapshots of `pcstatus`, `fifo_full`, `discriminator` and full_events are captured on the cycle the frame starts. They stay constant for the whole frame.
- FSM states:
  - IDLE: if a trigger or pending request is present → SEND with idx=0.
  - SEND: when the current byte is accepted, idx increments. When B4 is accepted → IDLE.
- Triggers: `report_req`=1, or the period timer expiring. The period timer counts 0..POLL_PERIOD-1 and fires at wrap; it runs continuously, including during frames.
- A trigger that arrives while a frame is active, or in the same cycle as B4 acceptance, sets `pending`. Any number of such triggers set only one pending flag. `pending` is cleared when the next frame starts.
- full_events:
  - 8-bit count of `fifo_full` rising edges, saturating at 255.
  - Snapshotted at frame start and cleared to 0 at the same time.
  - A rising edge detected in the snapshot cycle makes the counter 1 after the clear.
- `seq`: 2-bit counter that increments when B4 is accepted; wraps 3→0.
- Output values after reset:
  - `tx_valid`=0, `tx_data`=0, `busy`=0
  - state=IDLE, `pending`=0, `seq`=0, full_events=0, period timer=0, edge register=0

## Timing
- `report_req` high in cycle N while IDLE → `tx_valid`=1 and `tx_data`=`HEADER` registered at N+1.
- Every output is registered.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold constant.
- At most one byte is accepted per cycle. If `tx_ready` is held at 1, the 5-byte frame takes 5 cycles.
- After B4 is accepted, `tx_valid`=0 for at least one cycle (IDLE). A pending frame starts in the following cycle, so B0 appears 2 cycles after B4 acceptance.
- `busy` is 1 from the first B0 cycle through the B4 acceptance cycle.
- `reset_n` asserted mid-frame aborts the frame immediately. All state returns to reset values and no partial-frame continuation occurs.
- `fifo_full` is synchronous to `clock`; the edge detector uses a registered previous value.

## Structure
- Shared package `status_pkg`:
  - state enum (IDLE, SEND)
  - `FRAME_LEN`=5
  - byte index constants `IDX_HDR`..`IDX_CHK`
  - default `HEADER` value
- Sub-module `full_event_counter`:
  - inputs: `clock`, `reset_n`, `fifo_full`, clear
  - output: saturating 8-bit count
  - performs the rising-edge detect, saturation and the clear/edge-coincidence rule
- The top level holds the FSM, snapshot registers, checksum, `seq`, `pending` and the period timer.

## Test plan
- Reset, then `report_req`, with `tx_ready`=1, `pcstatus`=1, `fifo_full`=0, `discriminator`=8'h48, no prior full events:
  - bytes A5, 80, 48, 00, 6D on 5 consecutive cycles
  - `seq` becomes 1
- Three `fifo_full` pulses, then request:
  - B3=03
  - next frame B3=00
- 300 `fifo_full` pulses, then request: B3=FF (saturated).
- `tx_ready` toggled randomly during a frame:
  - every byte is held stable until accepted
  - byte order and values are unchanged
  - `discriminator` changed mid-frame does not alter B2
- Two `report_req` pulses during a frame:
  - exactly one extra frame follows
  - its B0 appears 2 cycles after the first frame's B4 acceptance
- `POLL_PERIOD`=20 with `tx_ready`=1: a frame starts every 20 cycles. Then `reset_n` pulsed low during B2: `tx_valid`=0 immediately and `seq`=0.
